// File: rtl/fir_pkg.sv
// fir_pkg: constants and sample type shared by the CSD FIR and its output stage
package fir_pkg;
    localparam int FIR_DATA_W = 16;
    localparam int FIR_ACC_W  = 32;
    typedef logic signed [FIR_DATA_W-1:0] sample_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: synchronous FIFO with a registered head output that holds its last value when empty
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_dout;
    logic [AW:0]      r_wr, r_rd, w_wr_nxt, w_rd_nxt;
    assign w_wr_nxt = r_wr + {{AW{1'b0}}, push};
    assign w_rd_nxt = r_rd + {{AW{1'b0}}, pop};
    assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign empty = r_wr == r_rd;
    assign count = r_wr - r_rd;
    assign dout  = r_dout;
    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr[AW-1:0]] <= din;
    end
    // Head is re-registered every cycle; a sample written this cycle may become the new head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_dout <= '0;
        end else if (clr) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_dout <= '0;
        end else begin
            r_wr <= w_wr_nxt;
            r_rd <= w_rd_nxt;
            if (w_wr_nxt != w_rd_nxt)
                r_dout <= (push && r_wr == w_rd_nxt) ? din : r_mem[w_rd_nxt[AW-1:0]];
        end
    end
endmodule

// File: rtl/fir_output_stage.sv
// fir_output_stage: decimates FIR results, buffers kept samples and streams them out,
// counting samples lost to back-pressure
module fir_output_stage
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_W,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [PW-1:0]                 r_phase;
    logic                          r_overflow;
    logic [CNT_WIDTH-1:0]          r_drop_cnt;
    logic                          w_keep, w_pop, w_push, w_drop, w_full, w_empty;
    logic [$clog2(FIFO_DEPTH):0]   w_count;
    assign w_keep  = in_valid && (r_phase == '0) && !clr;
    assign w_pop   = !w_empty && m_ready && !clr;
    assign w_push  = w_keep && ((w_count < FIFO_DEPTH) || w_pop);
    assign w_drop  = w_keep && w_full && !w_pop;
    assign m_valid  = !w_empty;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
    fir_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (in_data),
        .dout  (m_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_phase    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (in_valid)
                r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1)
                    r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage: directed vector bench for decimation, back-pressure, clr, async reset and saturation
module tb_fir_output_stage;
    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, m_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic [15:0] d4, d1, ds, c4, c1;
    logic [3:0]  cs;
    logic        v4, v1, vs, o4, o1, os;
    int total = 0, bad = 0;

    typedef struct {
        logic v; logic [15:0] d; logic r; logic c;
        logic ev; logic [15:0] ed; logic eo; logic [15:0] ec; logic cd;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fir_output_stage #(.DATA_WIDTH(16), .DECIM(4), .FIFO_DEPTH(4), .CNT_WIDTH(16)) u4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .clr(clr),
        .m_data(d4), .m_valid(v4), .m_ready(m_ready), .overflow(o4), .drop_cnt(c4));
    fir_output_stage #(.DATA_WIDTH(16), .DECIM(1), .FIFO_DEPTH(4), .CNT_WIDTH(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .clr(clr),
        .m_data(d1), .m_valid(v1), .m_ready(m_ready), .overflow(o1), .drop_cnt(c1));
    fir_output_stage #(.DATA_WIDTH(16), .DECIM(1), .FIFO_DEPTH(4), .CNT_WIDTH(4)) us (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .clr(clr),
        .m_data(ds), .m_valid(vs), .m_ready(m_ready), .overflow(os), .drop_cnt(cs));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input int d, input int r, input int c);
        in_valid = v[0]; in_data = d[15:0]; m_ready = r[0]; clr = c[0];
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int v, input int d, input int r, input int c,
                       input int ev, input int ed, input int eo, input int ec);
        vec_t x;
        x.v = v[0]; x.d = d[15:0]; x.r = r[0]; x.c = c[0];
        x.ev = ev[0]; x.ed = ed[15:0]; x.eo = eo[0]; x.ec = ec[15:0];
        x.cd = ev[0] | c[0];
        tbl.push_back(x);
    endtask

    initial begin
        // back-pressure fill on DECIM=1: 10..13 kept, 14 and 15 dropped, then drain
        add(1,10,0,0, 1,10,0,0); add(1,11,0,0, 1,10,0,0); add(1,12,0,0, 1,10,0,0);
        add(1,13,0,0, 1,10,0,0); add(1,14,0,0, 1,10,1,1); add(1,15,0,0, 1,10,1,2);
        add(0,0,1,0, 1,11,1,2);  add(0,0,1,0, 1,12,1,2);  add(0,0,1,0, 1,13,1,2);
        add(0,0,1,0, 0,0,1,2);
        // full FIFO with simultaneous push and pop: no drop, order preserved
        add(1,20,0,0, 1,20,1,2); add(1,21,0,0, 1,20,1,2); add(1,22,0,0, 1,20,1,2);
        add(1,23,0,0, 1,20,1,2); add(1,24,1,0, 1,21,1,2); add(1,25,1,0, 1,22,1,2);
        add(0,0,1,0, 1,23,1,2);  add(0,0,1,0, 1,24,1,2);  add(0,0,1,0, 1,25,1,2);
        add(0,0,1,0, 0,0,1,2);
        // clr with three entries queued and a sample arriving
        add(1,30,0,0, 1,30,1,2); add(1,31,0,0, 1,30,1,2); add(1,32,0,0, 1,30,1,2);
        add(1,33,1,1, 0,0,0,0);  add(1,34,1,0, 1,34,0,0); add(0,0,1,0, 0,0,0,0);
        // single-entry push and pop together
        add(1,40,1,0, 1,40,0,0); add(1,41,1,0, 1,41,0,0); add(0,0,1,0, 0,0,0,0);

        #2;
        chk("rst_valid", int'(v1), 0); chk("rst_data", int'(d1), 0);
        chk("rst_ovf", int'(o1), 0);   chk("rst_cnt", int'(c1), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            drive(1, k, 1, 0);
            chk($sformatf("dec_valid[%0d]", k), int'(v4), int'(k % 4 == 0));
            if (k % 4 == 0) chk($sformatf("dec_data[%0d]", k), int'(d4), k);
            chk($sformatf("dec_ovf[%0d]", k), int'(o4), 0);
        end

        drive(0, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(int'(tbl[i].v), int'(tbl[i].d), int'(tbl[i].r), int'(tbl[i].c));
            chk($sformatf("vec%0d_valid", i), int'(v1), int'(tbl[i].ev));
            if (tbl[i].cd) chk($sformatf("vec%0d_data", i), int'(d1), int'(tbl[i].ed));
            chk($sformatf("vec%0d_ovf", i), int'(o1), int'(tbl[i].eo));
            chk($sformatf("vec%0d_cnt", i), int'(c1), int'(tbl[i].ec));
            if (i == 24) begin
                chk("clr_phase_valid", int'(v4), 1);
                chk("clr_phase_data", int'(d4), 34);
            end
        end

        for (int k = 0; k < 5; k++) drive(1, 50 + k, 0, 0);
        chk("pre_arst_ovf", int'(o1), 1);
        chk("pre_arst_valid", int'(v1), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(v1), 0); chk("arst_data", int'(d1), 0);
        chk("arst_ovf", int'(o1), 0);   chk("arst_cnt", int'(c1), 0);
        #2;
        rst_n = 1'b1;
        drive(1, 60, 0, 0);
        chk("post_arst_valid", int'(v1), 1);
        chk("post_arst_data", int'(d1), 60);
        drive(0, 0, 1, 0);
        chk("post_arst_empty", int'(v1), 0);

        for (int k = 0; k < 24; k++) begin
            drive(1, 100 + k, 0, 0);
            chk($sformatf("sat_cnt[%0d]", k), int'(cs), (k < 4) ? 0 : ((k - 3 > 15) ? 15 : k - 3));
        end
        chk("sat_wide_cnt", int'(c1), 20);
        chk("sat_head", int'(ds), 100);
        chk("sat_ovf", int'(os), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_output_stage.md
# fir_output_stage

Downstream stage of the CSD FIR filter.
- Consumes the filter's single-cycle `valid_out`/`data_out` pulses, keeps one result in every DECIM, and buffers kept samples in a small FIFO.
- Presents buffered samples on a valid/ready stream to the next consumer (DAC formatter or bus bridge).
- Records any samples lost to back-pressure.

## Interface
- DATA_WIDTH, 16, sample width; matches the FIR output width.
- DECIM, 4, decimation factor; legal range 1..256; 1 means pass-through.
- FIFO_DEPTH, 4, buffer entries; power of two, ≥2.
- CNT_WIDTH, 16, width of the dropped-sample counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_data  in  DATA_WIDTH  FIR result, signed; sampled only when in_valid=1.
- in_valid  in  1  FIR result strobe; may be high on consecutive cycles.
- clr  in  1  synchronous flush: clears phase, FIFO, overflow and drop_cnt.
- m_data  out  DATA_WIDTH  head-of-FIFO sample.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid&&m_ready.
- overflow  out  1  sticky; set when a kept sample is dropped.
- drop_cnt  out  CNT_WIDTH  count of dropped kept samples; saturates at all-ones.

## Operation
- **Phase counter:** 0..DECIM-1.
  - Advances on every in_valid and wraps DECIM-1→0.
  - A sample is "kept" when in_valid=1 and phase==0; all others are discarded silently (not counted as drops).
- **Push:** a kept sample is written to the FIFO tail when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- **Drop:** if the FIFO is full and no pop occurs in that cycle, the kept sample is dropped.
  - overflow←1.
  - drop_cnt increments unless already saturated.
- **Pop:** on m_valid&&m_ready. The head advances and m_data shows the next entry in the following cycle.
- **Empty FIFO:**
  - m_valid=0.
  - m_data holds its last value (0 after reset/clr); consumers must not rely on it.
- **Pointers:** read/write pointers are log2(FIFO_DEPTH)+1 bits. Full = MSBs differ and LSBs equal; empty = pointers equal. Wrap-around is natural modulo 2·FIFO_DEPTH.
- **clr precedence:** clr has priority over in_valid and m_ready in the same cycle. The incoming sample is discarded and the pop is ignored.
- **Stalled consumer:** when m_ready is held low, occupancy saturates at FIFO_DEPTH. No data is corrupted; only new kept samples are dropped.
- **Arithmetic:** data passes unmodified. No rounding or sign extension.

## Timing
- **Reset values (rst_n=0):**
  - m_valid=0, m_data=0, overflow=0, drop_cnt=0.
  - Phase=0; pointers=0.
  - Reset can be asserted mid-operation; FIFO contents are then invalid.
- **Latency:** a kept sample pushed into an empty FIFO at edge N gives m_valid=1 with m_data=sample after edge N (same cycle as push+1). There is no combinational path from in_valid to m_valid.
- **m_valid and m_data:** both are registered or decoded from registered pointers. There is no combinational path from m_ready to any output.
- **Throughput:** one push and one pop per cycle sustained.
- **drop_cnt and overflow:** both update at the edge where the drop occurs.
- **clr:** outputs read as reset values from the cycle after clr=1.

## Structure
- Shared package fir_pkg holds:
  - Default DATA_WIDTH/ACC_WIDTH constants, shared with the FIR.
  - A typedef for the signed sample type.
- One sub-module: **fir_sync_fifo**, parameterised by width and depth, with push/pop/full/empty/count. This block adds the phase counter, drop logic and stream handshake around it.
- Target size: about 200 lines total.

## Test plan
- **Decimation:** DECIM=4, m_ready=1, feed in_valid every cycle with in_data=0,1,2,…,15 → m_data sequence 0,4,8,12; each m_valid appears one cycle after its push; overflow=0.
- **Back-pressure fill:** DECIM=1, FIFO_DEPTH=4, m_ready=0, push 6 samples 10..15 → FIFO holds 10..13; drop_cnt=2; overflow=1. Release m_ready → outputs 10,11,12,13, then m_valid=0.
- **Simultaneous push/pop on full:** full FIFO, m_ready=1 and a kept sample arrive in the same cycle → no drop; drop_cnt unchanged; order preserved.
- **clr mid-stream:** clr with 3 entries queued and in_valid=1 in the same cycle → next cycle m_valid=0, overflow=0, drop_cnt=0; next kept sample is the first in_valid after clr.
- **Async reset mid-operation:** drop rst_n between clock edges while m_valid=1 → m_valid, m_data, overflow and drop_cnt go to 0 immediately; normal operation resumes after release.
- **Saturation:** CNT_WIDTH=4, hold m_ready=0, drop 20 samples → drop_cnt=15 and holds there.
